// File: rtl/stage_counter.sv
`default_nettype none
// ============================================================================
// Module      : stage_counter
// Description : Pipeline stage sequencer for the multi-cycle core. Leaves
//               idle (0) for stage FIRST, steps FIRST..LAST and wraps back to
//               FIRST, counting each LAST->FIRST wrap as a retired
//               instruction. Supports stall, restart (flush) and recovers
//               from illegal stage codes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH  width of the stage output
//   FIRST  first stage after idle or wrap (1 <= FIRST <= LAST)
//   LAST   final stage (LAST < 2**WIDTH)
//   RET_W  width of the retired-instruction counter
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-low reset
//   en_i       in   advance enable
//   stall_i    in   hold the current stage
//   restart_i  in   flush: next stage = FIRST
//   out        out  current stage, 0 = idle
//   first_o    out  out == FIRST
//   wrap_o     out  out == LAST
//   retired_o  out  LAST->FIRST wrap count since reset (modulo 2**RET_W)
//   onehot_o   out  one-hot copy of out, present only when the macro
//                   STAGE_CNT_ONEHOT_EN is defined
// ============================================================================
module stage_counter #(
  parameter int WIDTH = 3,
  parameter int FIRST = 1,
  parameter int LAST  = 5,
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             stall_i,
  input  logic             restart_i,
  output logic [WIDTH-1:0] out,
  output logic             first_o,
  output logic             wrap_o,
  output logic [RET_W-1:0] retired_o
`ifdef STAGE_CNT_ONEHOT_EN
  ,
  output logic [LAST:0]    onehot_o
`endif
);

  localparam logic [WIDTH-1:0] FIRST_W = WIDTH'(FIRST);
  localparam logic [WIDTH-1:0] LAST_W  = WIDTH'(LAST);

  generate
    if ((FIRST < 1) || (FIRST > LAST) || (LAST >= (2 ** WIDTH))) begin : g_bad_params
      $error("stage_counter: illegal parameters FIRST=%0d LAST=%0d WIDTH=%0d",
             FIRST, LAST, WIDTH);
    end
  endgenerate

  logic [WIDTH-1:0] out_q, out_d;
  logic [RET_W-1:0] retired_q, retired_d;
  logic             illegal;

  // Codes strictly between idle and FIRST, or above LAST, are unreachable in
  // normal operation; treat them as corruption and resynchronise.
  assign illegal = ((out_q != '0) && (out_q < FIRST_W)) || (out_q > LAST_W);

  always_comb begin
    out_d     = out_q;
    retired_d = retired_q;
    if (restart_i || illegal) begin
      // Restart and recovery both land on FIRST and never count a retire.
      out_d = FIRST_W;
    end else if (stall_i) begin
      out_d = out_q;
    end else if (en_i) begin
      if (out_q == '0) begin
        out_d = FIRST_W;
      end else if (out_q == LAST_W) begin
        out_d     = FIRST_W;
        retired_d = retired_q + RET_W'(1);
      end else begin
        out_d = out_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q     <= '0;
      retired_q <= '0;
    end else begin
      out_q     <= out_d;
      retired_q <= retired_d;
    end
  end

  assign out       = out_q;
  assign retired_o = retired_q;
  assign first_o   = (out_q == FIRST_W);
  assign wrap_o    = (out_q == LAST_W);

`ifdef STAGE_CNT_ONEHOT_EN
  logic [LAST:0] onehot_q, onehot_d;

  // Built from the next stage so the one-hot flops track out exactly.
  always_comb begin
    onehot_d = '0;
    for (int i = 0; i <= LAST; i++) begin
      onehot_d[i] = (out_d == WIDTH'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      onehot_q <= {{LAST{1'b0}}, 1'b1};
    end else begin
      onehot_q <= onehot_d;
    end
  end

  assign onehot_o = onehot_q;
`else
  // No one-hot stage decode in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_counter
// Description : Directed self-checking bench for stage_counter with the
//               default parameters (WIDTH=3, FIRST=1, LAST=5, RET_W=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_counter;

  logic        clk;
  logic        reset;
  logic        en_i;
  logic        stall_i;
  logic        restart_i;
  logic [2:0]  out;
  logic        first_o;
  logic        wrap_o;
  logic [31:0] retired_o;
`ifdef STAGE_CNT_ONEHOT_EN
  logic [5:0]  onehot_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  stage_counter #(
    .WIDTH (3),
    .FIRST (1),
    .LAST  (5),
    .RET_W (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en_i      (en_i),
    .stall_i   (stall_i),
    .restart_i (restart_i),
    .out       (out),
    .first_o   (first_o),
    .wrap_o    (wrap_o),
    .retired_o (retired_o)
`ifdef STAGE_CNT_ONEHOT_EN
    ,
    .onehot_o  (onehot_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare all outputs against the expected stage and retire count.
  task automatic expect_state(input string tag, input int exp_out, input int exp_ret);
    check({tag, ".out"},     64'(out),       64'(exp_out));
    check({tag, ".retired"}, 64'(retired_o), 64'(exp_ret));
    check({tag, ".first"},   64'(first_o),   64'(exp_out == 1));
    check({tag, ".wrap"},    64'(wrap_o),    64'(exp_out == 5));
`ifdef STAGE_CNT_ONEHOT_EN
    check({tag, ".onehot"},  64'(onehot_o),  64'(1) << exp_out);
`endif
  endtask

  initial begin
    reset     = 1'b0;
    en_i      = 1'b1;
    stall_i   = 1'b0;
    restart_i = 1'b0;
    step();
    step();
    expect_state("reset", 0, 0);

    // Free run: 1,2,3,4,5 then wrap to 1 with one retire.
    reset = 1'b1;
    step(); expect_state("run1", 1, 0);
    step(); expect_state("run2", 2, 0);
    step(); expect_state("run3", 3, 0);
    step(); expect_state("run4", 4, 0);
    step(); expect_state("run5", 5, 0);
    step(); expect_state("wrap1", 1, 1);
    step(); expect_state("run2b", 2, 1);

    // Restart and stall together at stage 2: restart wins.
    restart_i = 1'b1;
    stall_i   = 1'b1;
    step(); expect_state("rst_stall", 1, 1);
    restart_i = 1'b0;
    stall_i   = 1'b0;
    step(); expect_state("run2c", 2, 1);
    step(); expect_state("run3c", 3, 1);

    // Stall three cycles at stage 3, then continue 4,5,1.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_state("stall3", 3, 1);
    end
    stall_i = 1'b0;
    step(); expect_state("post_st4", 4, 1);
    step(); expect_state("post_st5", 5, 1);
    step(); expect_state("wrap2", 1, 2);
    step(); expect_state("run2d", 2, 2);
    step(); expect_state("run3d", 3, 2);
    step(); expect_state("run4d", 4, 2);

    // Restart at stage 4: back to 1 with no retire.
    restart_i = 1'b1;
    step(); expect_state("restart4", 1, 2);
    restart_i = 1'b0;

    // Enable low holds.
    en_i = 1'b0;
    step(); expect_state("hold_a", 1, 2);
    step(); expect_state("hold_b", 1, 2);
    en_i = 1'b1;
    step(); expect_state("run2e", 2, 2);
    step(); expect_state("run3e", 3, 2);
    step(); expect_state("run4e", 4, 2);

    // Mid-sequence reset at stage 4, then release.
    reset = 1'b0;
    step(); expect_state("midreset", 0, 0);
    reset = 1'b1;
    step(); expect_state("rel1", 1, 0);

    // From idle with enable low: stays idle until restart forces FIRST.
    reset = 1'b0;
    step();
    reset = 1'b1;
    en_i  = 1'b0;
    step(); expect_state("idle_hold", 0, 0);
    restart_i = 1'b1;
    step(); expect_state("idle_restart", 1, 0);
    restart_i = 1'b0;

    // Stall while idle keeps idle even with enable high.
    reset = 1'b0;
    step();
    reset   = 1'b1;
    en_i    = 1'b1;
    stall_i = 1'b1;
    step(); expect_state("idle_stall", 0, 0);
    stall_i = 1'b0;
    step(); expect_state("idle_go", 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
